// File: rtl/madd_pkg.sv
// Shared definitions for the lower-part-OR approximate adder family.
package madd_pkg;

    // Operand width the family is normally built for.
    localparam int unsigned MADD_DEF_WIDTH = 8;

    // Sum (and error) width for a given operand width: one carry bit on top.
    function automatic int unsigned madd_sum_w(input int unsigned width);
        return width + 1;
    endfunction

    // Per-transaction result at the default operand width.
    typedef struct packed {
        logic [MADD_DEF_WIDTH:0] sum;
        logic [MADD_DEF_WIDTH:0] err;
        logic                    viol;
    } madd_result_t;

endpackage

// File: rtl/madd_lpa_core.sv
// Combinational core: exact sum, lower-part-OR approximate sum and their
// absolute difference. No state; also used standalone by the XPAT flow.
module madd_lpa_core #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned APPROX_BITS = 3
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH:0]   o_exact,
    output logic [WIDTH:0]   o_approx,
    output logic [WIDTH:0]   o_err
);

    assign o_exact = {1'b0, i_a} + {1'b0, i_b};

    generate
        if (APPROX_BITS == 0) begin : g_exact
            // Nothing approximated: both sums coincide.
            assign o_approx = o_exact;
        end else if (APPROX_BITS == WIDTH) begin : g_full
            // Whole operand ORed; the only upper bit left is the MSB carry guess.
            assign o_approx = {i_a[WIDTH-1] & i_b[WIDTH-1], i_a | i_b};
        end else begin : g_split
            localparam int unsigned HW = WIDTH - APPROX_BITS;
            logic          w_c;
            logic [HW:0]   w_hi;
            // Carry into the exact part is guessed from the top approximated bit pair.
            assign w_c  = i_a[APPROX_BITS-1] & i_b[APPROX_BITS-1];
            assign w_hi = {1'b0, i_a[WIDTH-1:APPROX_BITS]}
                        + {1'b0, i_b[WIDTH-1:APPROX_BITS]}
                        + {{HW{1'b0}}, w_c};
            assign o_approx = {w_hi, i_a[APPROX_BITS-1:0] | i_b[APPROX_BITS-1:0]};
        end
    endgenerate

    assign o_err = (o_exact >= o_approx) ? (o_exact - o_approx) : (o_approx - o_exact);

endmodule

// File: rtl/madd_lpa_pipe.sv
// Two-stage pipelined approximate adder with error monitor and statistics.
// Handshake: a transfer happens on a cycle where valid && ready are both high;
// valid never depends on ready, and out_* are held while out_valid && !out_ready.
module madd_lpa_pipe
    import madd_pkg::*;
#(
    parameter int unsigned WIDTH       = MADD_DEF_WIDTH,
    parameter int unsigned APPROX_BITS = 3,
    parameter int unsigned ET          = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_a,
    input  logic [WIDTH-1:0]    in_b,
    input  logic                in_mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH:0]      out_sum,
    output logic [WIDTH:0]      out_err,
    output logic                out_viol,
    input  logic                clr_stats,
    output logic [CNT_W-1:0]    stat_cnt,
    output logic [WIDTH:0]      stat_max,
    output logic                stat_flag
);

    localparam int unsigned      SUM_W   = madd_sum_w(WIDTH);
    localparam logic [SUM_W-1:0] ET_V    = SUM_W'(ET);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic [SUM_W-1:0] sum;
        logic [SUM_W-1:0] err;
        logic             viol;
    } result_t;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_mode;
    logic             r_out_valid;
    result_t          r_res;
    logic [CNT_W-1:0] r_stat_cnt;
    logic [SUM_W-1:0] r_stat_max;
    logic             r_stat_flag;

    logic             w_s2_load;
    logic             w_out_hs;
    logic [SUM_W-1:0] w_exact;
    logic [SUM_W-1:0] w_approx;
    logic [SUM_W-1:0] w_err;
    result_t          w_res;
    logic [CNT_W-1:0] w_cnt_base;
    logic [SUM_W-1:0] w_max_base;
    logic             w_flag_base;
    logic [CNT_W-1:0] w_cnt_next;
    logic [SUM_W-1:0] w_max_next;
    logic             w_flag_next;

    assign w_s2_load = !r_out_valid || out_ready;
    assign w_out_hs  = r_out_valid && out_ready;
    assign in_ready  = !r_s1_valid || w_s2_load;

    madd_lpa_core #(
        .WIDTH       (WIDTH),
        .APPROX_BITS (APPROX_BITS)
    ) u_core (
        .i_a      (r_s1_a),
        .i_b      (r_s1_b),
        .o_exact  (w_exact),
        .o_approx (w_approx),
        .o_err    (w_err)
    );

    assign w_res.sum  = r_s1_mode ? w_exact : w_approx;
    assign w_res.err  = w_err;
    assign w_res.viol = (w_err > ET_V);

    // Stage 1: capture operands and mode whenever the stage can move.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_mode  <= 1'b0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a    <= in_a;
                r_s1_b    <= in_b;
                r_s1_mode <= in_mode;
            end
        end
    end

    // Stage 2: register the selected sum and error verdict; hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_res       <= '0;
        end else if (w_s2_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_res <= w_res;
            end
        end
    end

    // Statistics next-state: a same-cycle clear wipes the old values before the handshake is recorded.
    always_comb begin
        w_cnt_base  = clr_stats ? '0   : r_stat_cnt;
        w_max_base  = clr_stats ? '0   : r_stat_max;
        w_flag_base = clr_stats ? 1'b0 : r_stat_flag;
        w_cnt_next  = w_cnt_base;
        w_max_next  = w_max_base;
        w_flag_next = w_flag_base;
        if (w_out_hs) begin
            if (r_res.viol && (w_cnt_base != CNT_MAX)) begin
                w_cnt_next = w_cnt_base + CNT_W'(1);
            end
            if (r_res.err > w_max_base) begin
                w_max_next = r_res.err;
            end
            if (r_res.viol) begin
                w_flag_next = 1'b1;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_cnt  <= '0;
            r_stat_max  <= '0;
            r_stat_flag <= 1'b0;
        end else begin
            r_stat_cnt  <= w_cnt_next;
            r_stat_max  <= w_max_next;
            r_stat_flag <= w_flag_next;
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_res.sum;
    assign out_err   = r_res.err;
    assign out_viol  = r_res.viol;
    assign stat_cnt  = r_stat_cnt;
    assign stat_max  = r_stat_max;
    assign stat_flag = r_stat_flag;

endmodule

// File: tb/tb_madd_lpa_pipe.sv
// Bench for madd_lpa_pipe (WIDTH=8, APPROX_BITS=3, ET=2) plus a CNT_W=2 copy
// sharing the same stimulus for the counter saturation corner.
module tb_madd_lpa_pipe;

  localparam int K  = 3;
  localparam int ET = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid, in_mode, out_ready, clr_stats;
  logic [7:0] in_a, in_b;
  logic       in_ready, out_valid, out_viol, stat_flag;
  logic [8:0] out_sum, out_err, stat_max;
  logic [15:0] stat_cnt;

  logic       s_in_ready, s_out_valid, s_out_viol, s_stat_flag;
  logic [8:0] s_out_sum, s_out_err, s_stat_max;
  logic [1:0] s_stat_cnt;

  madd_lpa_pipe #(.WIDTH(8), .APPROX_BITS(3), .ET(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_err(out_err), .out_viol(out_viol), .clr_stats(clr_stats),
    .stat_cnt(stat_cnt), .stat_max(stat_max), .stat_flag(stat_flag)
  );

  madd_lpa_pipe #(.WIDTH(8), .APPROX_BITS(3), .ET(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_sum(s_out_sum),
    .out_err(s_out_err), .out_viol(s_out_viol), .clr_stats(clr_stats),
    .stat_cnt(s_stat_cnt), .stat_max(s_stat_max), .stat_flag(s_stat_flag)
  );

  // ---------------- scoreboard state ----------------
  int n_assert = 0;
  int n_fail   = 0;
  logic [18:0] exp_q[$];     // {sum[8:0], err[8:0], viol}
  logic [18:0] next_exp;
  int   m_cnt, m_sat, m_max;
  bit   m_flag;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: approximate adder evaluated with integer arithmetic.
  function automatic logic [18:0] ref_model(input int a, input int b, input bit mode);
    int lo, c, hi, ap, ex, er;
    ex = a + b;
    lo = (a % (1 << K)) | (b % (1 << K));
    c  = ((a >> (K - 1)) % 2) * ((b >> (K - 1)) % 2);
    hi = (a >> K) + (b >> K) + c;
    ap = hi * (1 << K) + lo;
    er = (ex > ap) ? ex - ap : ap - ex;
    return {9'(mode ? ex : ap), 9'(er), (er > ET) ? 1'b1 : 1'b0};
  endfunction

  // One clock cycle: observe handshakes, score outputs, advance, check stats.
  task automatic cycle(output bit acc);
    bit del;
    bit have;
    logic [18:0] e;
    #1;
    acc  = in_valid && in_ready;
    del  = out_valid && out_ready;
    have = 1'b0;
    e    = '0;
    chk("in_ready", in_ready, !(exp_q.size() == 2 && !out_ready));
    if (out_valid && exp_q.size() == 0) chk("spurious_valid", out_valid, 0);
    if (del && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      have = 1'b1;
      chk("out_sum",  out_sum,  e[18:10]);
      chk("out_err",  out_err,  e[9:1]);
      chk("out_viol", out_viol, e[0]);
    end
    if (clr_stats) begin
      m_cnt = 0; m_sat = 0; m_max = 0; m_flag = 0;
    end
    if (have) begin
      if (e[0]) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_sat < 3) m_sat++;
        m_flag = 1;
      end
      if (int'(e[9:1]) > m_max) m_max = int'(e[9:1]);
    end
    if (acc) exp_q.push_back(next_exp);
    @(posedge clk);
    #1;
    chk("stat_cnt",  stat_cnt,   m_cnt);
    chk("stat_max",  stat_max,   m_max);
    chk("stat_flag", stat_flag,  m_flag);
    chk("sat_cnt",   s_stat_cnt, m_sat);
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input bit mode, input bit v);
    in_a = a; in_b = b; in_mode = mode; in_valid = v;
    next_exp = ref_model(int'(a), int'(b), mode);
  endtask

  task automatic drain();
    bit acc;
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) cycle(acc);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       mode;
    logic [8:0] sum;
    logic [8:0] err;
    logic       viol;
  } vec_t;
  vec_t tbl[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int idx;

    tbl[0] = '{8'h07, 8'h01, 1'b0, 9'h007, 9'd1, 1'b0};
    tbl[1] = '{8'h03, 8'h03, 1'b0, 9'h003, 9'd3, 1'b1};
    tbl[2] = '{8'h07, 8'h07, 1'b1, 9'h00E, 9'd1, 1'b0};
    tbl[3] = '{8'hFF, 8'hFF, 1'b1, 9'h1FE, 9'd1, 1'b0};
    tbl[4] = '{8'h00, 8'h00, 1'b0, 9'h000, 9'd0, 1'b0};
    tbl[5] = '{8'hFF, 8'hFF, 1'b0, 9'h1FF, 9'd1, 1'b0};
    tbl[6] = '{8'h04, 8'h04, 1'b0, 9'h00C, 9'd4, 1'b1};
    tbl[7] = '{8'h05, 8'h02, 1'b0, 9'h007, 9'd0, 1'b0};
    tbl[8] = '{8'h80, 8'h80, 1'b0, 9'h100, 9'd0, 1'b0};

    m_cnt = 0; m_sat = 0; m_max = 0; m_flag = 0;
    rst = 1; in_valid = 0; in_mode = 0; in_a = 0; in_b = 0;
    out_ready = 1; clr_stats = 0; next_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum",   out_sum,   0);
    chk("rst_out_err",   out_err,   0);
    chk("rst_out_viol",  out_viol,  0);
    chk("rst_stat_cnt",  stat_cnt,  0);
    chk("rst_stat_max",  stat_max,  0);
    chk("rst_stat_flag", stat_flag, 0);
    chk("rst_in_ready",  in_ready,  1);
    rst = 0;

    // Table: one transaction at a time, latency checked, results from the table.
    foreach (tbl[i]) begin
      in_a = tbl[i].a; in_b = tbl[i].b; in_mode = tbl[i].mode; in_valid = 1;
      out_ready = 1;
      next_exp = {tbl[i].sum, tbl[i].err, tbl[i].viol};
      cycle(acc);
      chk("tbl_accept", acc, 1);
      in_valid = 0;
      chk("tbl_lat1_valid", out_valid, 0);
      cycle(acc);
      chk("tbl_lat2_valid", out_valid, 1);
      cycle(acc);
      if (i == 1) begin
        chk("t2_stat_cnt",  stat_cnt,  1);
        chk("t2_stat_flag", stat_flag, 1);
        chk("t2_stat_max",  stat_max,  3);
      end
    end

    // Back-to-back stream with out_ready low for 3 cycles.
    idx = 0;
    for (int cyc = 0; cyc < 20 && (idx < 4 || exp_q.size() > 0); cyc++) begin
      out_ready = (cyc >= 3);
      drive(8'(10 + idx), 8'(20 + idx), 1'b1, idx < 4);
      cycle(acc);
      if (acc) idx++;
      if (cyc == 2) chk("stall_accepted", idx, 2);
    end
    chk("stream_all_in", idx, 4);
    chk("stream_all_out", exp_q.size(), 0);

    // clr_stats coincident with a violating handshake.
    out_ready = 0;
    drive(8'h03, 8'h03, 1'b0, 1'b1);
    cycle(acc);
    in_valid = 0;
    cycle(acc);
    chk("clr_setup_valid", out_valid, 1);
    clr_stats = 1; out_ready = 1;
    cycle(acc);
    clr_stats = 0;
    chk("clr_stat_cnt",  stat_cnt,  1);
    chk("clr_stat_max",  stat_max,  3);
    chk("clr_stat_flag", stat_flag, 1);

    // Four more violations: wide counter reaches 5, 2-bit counter holds at 3.
    for (int i = 0; i < 4; i++) begin
      drive(8'h03, 8'h03, 1'b0, 1'b1);
      cycle(acc);
      if (!acc) i--;
    end
    drain();
    chk("sat_hold",  s_stat_cnt, 3);
    chk("cnt_after", stat_cnt,   5);

    // Randomized traffic against the reference model.
    for (int cyc = 0; cyc < 400; cyc++) begin
      drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      out_ready = $urandom_range(0, 3) != 0;
      clr_stats = $urandom_range(0, 29) == 0;
      cycle(acc);
    end
    clr_stats = 0;
    drain();

    // Asynchronous reset with both stages full.
    out_ready = 0;
    drive(8'h04, 8'h04, 1'b0, 1'b1);
    cycle(acc);
    drive(8'h07, 8'h07, 1'b0, 1'b1);
    cycle(acc);
    in_valid = 0;
    chk("full_valid", out_valid, 1);
    chk("full_in_ready", in_ready, 0);
    #1 rst = 1;
    #1;
    chk("arst_out_valid", out_valid,  0);
    chk("arst_stat_cnt",  stat_cnt,   0);
    chk("arst_stat_max",  stat_max,   0);
    chk("arst_stat_flag", stat_flag,  0);
    chk("arst_sat_cnt",   s_stat_cnt, 0);
    chk("arst_in_ready",  in_ready,   1);
    exp_q.delete();
    m_cnt = 0; m_sat = 0; m_max = 0; m_flag = 0;
    @(posedge clk);
    #1 rst = 0;
    out_ready = 1;
    drive(8'h05, 8'h07, 1'b0, 1'b1);
    cycle(acc);
    chk("post_rst_accept", acc, 1);
    in_valid = 0;
    cycle(acc);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_sum",   out_sum,   9'h00F);
    chk("post_rst_err",   out_err,   3);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
